// File: rtl/panda_mem_loader_pkg.sv
// panda_mem_loader_pkg: shared types and memory-select encoding for the PANDA
// stream-to-memory loader.
`default_nettype none

package panda_mem_loader_pkg;

  // Memory select encoding; values 0..6 double as the one-hot write-enable index.
  localparam int unsigned PANDA_FSM_SEL_CONFIG   = 0;
  localparam int unsigned PANDA_FSM_SEL_INSTR    = 1;
  localparam int unsigned PANDA_FSM_SEL_LUT      = 2;
  localparam int unsigned PANDA_FSM_SEL_SPARSITY = 3;
  localparam int unsigned PANDA_FSM_SEL_ACT      = 4;
  localparam int unsigned PANDA_FSM_SEL_CONV_W   = 5;
  localparam int unsigned PANDA_FSM_SEL_FC_W     = 6;
  localparam int unsigned PANDA_FSM_SEL_NULL     = 7;
  localparam int unsigned PANDA_NUM_MEMS         = 7;

  localparam int unsigned LOADER_ADDR_WIDTH = 16;
  localparam int unsigned LOADER_CNT_WIDTH  = 11;

  typedef enum logic [1:0] {
    LOADER_IDLE = 2'd0,
    LOADER_LOAD = 2'd1,
    LOADER_DONE = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic [2:0]                  mem_sel;
    logic [LOADER_ADDR_WIDTH-1:0] base_addr;
    logic [LOADER_CNT_WIDTH-1:0]  len;
    logic                        start;
  } ctrl_loader_t;

  typedef struct packed {
    logic [LOADER_CNT_WIDTH-1:0] cnt;
    logic                        busy;
    logic                        done;
  } flags_loader_t;

  // NULL (and any out-of-range code) maps to no enable at all.
  function automatic logic [PANDA_NUM_MEMS-1:0] sel_onehot(input logic [2:0] sel);
    logic [PANDA_NUM_MEMS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(PANDA_NUM_MEMS); i++) begin
      oh[i] = (sel == 3'(i));
    end
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/panda_mem_loader.sv
// +--------------------------------------------------------------------------+
// | panda_mem_loader: writes one HWPE input stream into a selected PANDA     |
// | on-chip memory at consecutive addresses.                  Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module panda_mem_loader
  import panda_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [2:0]            mem_sel_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  input  logic                  mem_ready_i,
  output logic [6:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  busy_o,
  output logic                  done_o
);

  loader_state_t         state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hs;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    hs          = 1'b0;
    mem_we_o    = '0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      LOADER_IDLE: begin
        if (start_i && !clear_i) begin
          sel_d   = mem_sel_i;
          addr_d  = base_addr_i;
          len_d   = len_i;
          cnt_d   = '0;
          state_d = (mem_sel_i == 3'(PANDA_FSM_SEL_NULL) || len_i == '0) ?
                    LOADER_DONE : LOADER_LOAD;
        end
      end
      LOADER_LOAD: begin
        busy_o = 1'b1;
        // Abort and reset must not let a word be consumed without being written.
        in_ready_o = mem_ready_i & ~clear_i & ~rst_i;
        hs         = in_valid_i & in_ready_o;
        if (hs) begin
          mem_we_o    = sel_onehot(sel_q);
          mem_wdata_o = in_data_i;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          cnt_d       = cnt_q + CNT_WIDTH'(1);
          if (cnt_q + CNT_WIDTH'(1) == len_q) begin
            state_d = LOADER_DONE;
          end
        end
      end
      LOADER_DONE: begin
        done_o  = ~clear_i;
        state_d = LOADER_IDLE;
      end
      default: state_d = LOADER_IDLE;
    endcase

    if (clear_i) begin
      state_d = LOADER_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOADER_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign cnt_o      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_panda_mem_loader.sv
// tb_panda_mem_loader: table-driven commands plus hand-written reset/clear
// sequences; every memory write is checked against a queue of expected writes.
`default_nettype none

module tb_panda_mem_loader;

  logic        clk = 1'b0;
  logic        rst, clear, start;
  logic [2:0]  sel;
  logic [15:0] base;
  logic [10:0] len;
  logic        valid;
  logic [31:0] data;
  logic        in_ready;
  logic        mem_ready;
  logic [6:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [10:0] cnt;
  logic        busy, done;

  panda_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CNT_WIDTH(11)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .mem_sel_i(sel), .base_addr_i(base), .len_i(len),
    .in_valid_i(valid), .in_data_i(data), .in_ready_o(in_ready),
    .mem_ready_i(mem_ready), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .cnt_o(cnt), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] base;
    logic [10:0] len;
    logic [15:0] rdy;   // mem_ready pattern, bit k used in LOAD cycle k+1
    int          lat;   // cycles from start to done_o
    int          cnt;
    int          busy;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vtab[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [2:0] s, input logic [15:0] b, input int i);
    logic [15:0] a;
    a = b + 16'(i);
    return {4'hA, 1'b0, s, 8'(i), a};
  endfunction

  task automatic push_exp(input logic [2:0] s, input logic [15:0] b, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.we   = 7'b1 << s;
      e.addr = b + 16'(i);
      e.data = word(s, b, i);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every write must match the next expected entry.
  always @(negedge clk) begin
    if (we !== 7'd0) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got we=0x%0h addr=0x%0h, expected no write", we, addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_we", 32'(we), 32'(e.we));
        check("wr_addr", 32'(addr), 32'(e.addr));
        check("wr_data", wdata, e.data);
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    int k, cyc, busy_n, wr0, nexp;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; sel = v.sel; base = v.base; len = v.len;
    valid = 1'b0; mem_ready = 1'b1;
    nexp = (v.sel != 3'd7 && v.len != 0) ? int'(v.len) : 0;
    push_exp(v.sel, v.base, nexp);
    wr0 = n_wr;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
    k = 0; cyc = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      start     = 1'b0;
      cyc++;
      valid     = (k < int'(v.len));
      data      = word(v.sel, v.base, k);
      mem_ready = v.rdy[(cyc - 1) % 16];
      @(negedge clk);
      if (busy) begin
        busy_n++;
        check({tag, "_ready_follows_mem"}, 32'(in_ready), 32'(mem_ready));
      end
      if (valid && in_ready) k++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_latency"}, 32'(cyc), 32'(v.lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.busy));
    check({tag, "_cnt"}, 32'(cnt), 32'(v.cnt));
    @(posedge clk); #1;
    valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_cnt_hold"}, 32'(cnt), 32'(v.cnt));
    check({tag, "_num_writes"}, 32'(n_wr - wr0), 32'(nexp));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst = 1'b1; clear = 1'b0; start = 1'b0; sel = '0; base = '0; len = '0;
    valid = 1'b0; data = '0; mem_ready = 1'b0;

    vtab[0] = '{3'd4, 16'h0100, 11'd4, 16'hFFFF, 5, 4, 4};   // back-to-back
    vtab[1] = '{3'd1, 16'h0020, 11'd3, 16'h5555, 6, 3, 5};   // ready 1,0,1,0,1
    vtab[2] = '{3'd7, 16'h0000, 11'd5, 16'hFFFF, 1, 0, 0};   // NULL select
    vtab[3] = '{3'd0, 16'h0000, 11'd0, 16'hFFFF, 1, 0, 0};   // zero length
    vtab[4] = '{3'd2, 16'hFFFE, 11'd4, 16'hFFFF, 5, 4, 4};   // address wrap
    vtab[5] = '{3'd6, 16'h1234, 11'd1, 16'hFFFF, 2, 1, 1};   // single word
    vtab[6] = '{3'd3, 16'h0040, 11'd6, 16'h3333, 11, 6, 10}; // 2-on/2-off stalls

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_cmd(vtab[t], $sformatf("vec%0d", t));
    end

    // Reset in the middle of a load after three writes.
    @(posedge clk); #1;
    start = 1'b1; sel = 3'd5; base = 16'h0300; len = 11'd8; valid = 1'b0; mem_ready = 1'b1;
    push_exp(3'd5, 16'h0300, 3);
    wr0 = n_wr;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0; valid = 1'b1; data = word(3'd5, 16'h0300, i);
    end
    @(posedge clk); #1;
    rst = 1'b1; data = word(3'd5, 16'h0300, 3);
    @(negedge clk);
    check("rstmid_no_write", 32'(we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    check("rstmid_we", 32'(we), 32'd0);
    check("rstmid_addr", 32'(addr), 32'd0);
    check("rstmid_wdata", wdata, 32'd0);
    check("rstmid_cnt", 32'(cnt), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_num_writes", 32'(n_wr - wr0), 32'd3);
    check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear on the second load cycle of a len=8 command.
    @(posedge clk); #1;
    start = 1'b1; sel = 3'd2; base = 16'h0500; len = 11'd8; valid = 1'b0; mem_ready = 1'b1;
    push_exp(3'd2, 16'h0500, 1);
    wr0 = n_wr;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; data = word(3'd2, 16'h0500, 0);
    @(posedge clk); #1;
    clear = 1'b1; data = word(3'd2, 16'h0500, 1);
    @(negedge clk);
    check("clr_no_write", 32'(we), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("clr_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("clr_num_writes", 32'(n_wr - wr0), 32'd1);
    check("clr_queue_empty", 32'(exp_q.size()), 32'd0);
    run_cmd(vtab[0], "post_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/panda_mem_loader.md
# panda_mem_loader

Stream-to-memory loader for the PANDA accelerator. It sits directly downstream of the MAC engine control FSM and its input streamer. It consumes the engine's memory-select/length/start command plus one HWPE input stream, and writes each accepted word into the selected PANDA on-chip memory (config, instruction, LUT, sparsity, activation, conv weight, FC weight) at consecutive addresses. It reports progress and completion back to the control FSM.

## Interface
Parameters:
- DATA_WIDTH, 32, stream and memory word width
- ADDR_WIDTH, 16, memory word-address width
- CNT_WIDTH, 11, word-count width ($clog2(1024)+1; count starts from 1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous abort; returns to IDLE with no done pulse
- start_i  in  1  command strobe; sampled only in IDLE
- mem_sel_i  in  3  target memory, PANDA_FSM_SEL_* encoding (7 = NULL)
- base_addr_i  in  ADDR_WIDTH  first write address
- len_i  in  CNT_WIDTH  number of words to load
- in_valid_i  in  1  input stream valid
- in_data_i  in  DATA_WIDTH  input stream data
- in_ready_o  out  1  input stream ready
- mem_ready_i  in  1  memory side can accept a write this cycle
- mem_we_o  out  7  one-hot write enable, bit = PANDA_FSM_SEL_* index
- mem_addr_o  out  ADDR_WIDTH  write address
- mem_wdata_o  out  DATA_WIDTH  write data
- cnt_o  out  CNT_WIDTH  words written in current command
- busy_o  out  1  high in LOAD
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready_o=0, mem_we_o=0.
  - On start_i, latch mem_sel_i, base_addr_i and len_i; clear cnt.
  - If mem_sel_i==7 or len_i==0, go to DONE. Otherwise go to LOAD.
- LOAD:
  - in_ready_o = mem_ready_i.
  - A handshake (in_valid_i & in_ready_o) asserts mem_we_o[sel] in the same cycle, with mem_addr_o = current address and mem_wdata_o = in_data_i.
  - On each handshake, address += 1 (modulo 2^ADDR_WIDTH, silent wrap) and cnt += 1.
  - The handshake where cnt+1 == len goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. cnt_o holds its final value until the next start.
- start_i outside IDLE is ignored.
- in_ready_o never depends on in_valid_i.
- mem_addr_o and mem_wdata_o are don't-care when mem_we_o==0.
- clear_i has priority over everything except rst_i. It forces IDLE in the next cycle, suppresses any write in the cycle it is asserted, and produces no done pulse.

## Timing
- Reset values: state IDLE, in_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0 (gated), cnt_o=0, busy_o=0, done_o=0.
- Start-to-first-write: start_i in cycle N, earliest write in cycle N+1.
- Stream-to-memory latency is 0 cycles (combinational pass-through).
- Throughput is 1 word/cycle when in_valid_i and mem_ready_i are both held high.
- A len=L command with no stalls: busy_o high for L cycles, done_o in cycle N+L+1.
- NULL select or len=0: done_o in cycle N+1, no writes.
- mem_ready_i low stalls with no state change. in_data_i must be held by the upstream streamer (HWPE stream rules).
- Reset or clear mid-LOAD: no further writes; any partial memory contents remain.

## Structure
- Add to mac_package:
  - loader_state_t enum {LOADER_IDLE, LOADER_LOAD, LOADER_DONE}.
  - ctrl_loader_t struct {mem_sel, base_addr, len, start}.
  - flags_loader_t struct {cnt, busy, done}.
- Reuse the existing PANDA_FSM_SEL_* constants as the one-hot index.
- Single module with no sub-module. The address/count logic is two registers.

## Test plan
- Reset mid-LOAD: sel=5, len=8, rst_i after 3 writes -> all outputs at reset values next cycle; exactly 3 writes on mem_we_o[5].
- Back-to-back stream: sel=4, base=0x0100, len=4, valid held high, mem_ready=1 -> writes at 0x0100..0x0103 in 4 consecutive cycles; done_o one cycle later; cnt_o=4.
- Backpressure: sel=1, len=3, mem_ready toggling 1,0,1,0,1 -> exactly 3 writes, in_ready_o low on stall cycles, no duplicated addresses.
- NULL/zero length: sel=7, len=5 and sel=0, len=0 -> done_o in cycle N+1, mem_we_o stays 0.
- Wrap-around: base=0xFFFE, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Clear abort: clear_i at cycle 2 of len=8 -> IDLE next cycle, no done_o; a subsequent start_i is accepted normally.
